// File: rtl/fabric_pkg.sv
// Shared types and the default SoC memory map
// for the data-bus fabric.
package fabric_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_RO_WRITE = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_e;

  localparam int DEF_N_TGT = 5;
  localparam int DEF_AW    = 32;

  // Slot 0 sits in the LSBs: rom, fram, ram, pwr, uart.
  localparam logic [DEF_N_TGT*DEF_AW-1:0] DEF_BASES = {
    32'h4000_1000,
    32'h4000_0000,
    32'h2000_0000,
    32'h1000_0000,
    32'h0000_0000
  };

  localparam logic [DEF_N_TGT*DEF_AW-1:0] DEF_MASKS = {
    32'hFFFF_F000,
    32'hFFFF_F000,
    32'hFF00_0000,
    32'hFF00_0000,
    32'hFF00_0000
  };

endpackage

// File: rtl/bus_addr_decode.sv
// Base/mask address decoder with
// lowest-index priority on overlapping windows.
module bus_addr_decode
  import fabric_pkg::*;
#(
  parameter int N_TGT  = DEF_N_TGT,
  parameter int ADDR_W = DEF_AW,
  parameter logic [N_TGT*ADDR_W-1:0] BASES = DEF_BASES,
  parameter logic [N_TGT*ADDR_W-1:0] MASKS = DEF_MASKS,
  parameter int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [N_TGT-1:0]  o_hit,
  output logic [N_TGT-1:0]  o_sel,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  // Per-window match against base under mask.
  always_comb begin
    o_hit = '0;
    for (int i = 0; i < N_TGT; i++) begin
      o_hit[i] = ((i_addr & MASKS[i*ADDR_W +: ADDR_W])
                  == BASES[i*ADDR_W +: ADDR_W]);
    end
  end

  // Scan high to low so the lowest hit is last written.
  always_comb begin
    o_sel = '0;
    o_idx = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if (o_hit[i]) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_idx    = IDX_W'(i);
      end
    end
  end

  assign o_any = |o_hit;

endmodule

// File: rtl/bus_fabric.sv
// Ibex data-port to N-target interconnect with
// registered response, timeouts and an error log.
module bus_fabric
  import fabric_pkg::*;
#(
  parameter int N_TGT  = DEF_N_TGT,
  parameter int ADDR_W = DEF_AW,
  parameter int DATA_W = 32,
  parameter logic [N_TGT*ADDR_W-1:0] BASES = DEF_BASES,
  parameter logic [N_TGT*ADDR_W-1:0] MASKS = DEF_MASKS,
  parameter logic [N_TGT-1:0] RO_MASK = 5'b00001,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [DATA_W/8-1:0]     host_be,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [DATA_W-1:0]       host_wdata,
  output logic                    host_gnt,
  output logic                    host_rvalid,
  output logic [DATA_W-1:0]       host_rdata,
  output logic                    host_err,
  output logic [N_TGT-1:0]        tgt_valid,
  output logic [ADDR_W-1:0]       tgt_addr,
  output logic [DATA_W-1:0]       tgt_wdata,
  output logic [DATA_W/8-1:0]     tgt_wstrb,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [N_TGT-1:0]        tgt_ready,
  output logic [7:0]              err_count,
  output logic [ADDR_W-1:0]       last_err_addr,
  output logic [1:0]              last_err_cause
);

  localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] W_MAX = CW'(TIMEOUT);

  logic [N_TGT-1:0]  w_hit;
  logic [N_TGT-1:0]  w_sel;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic              w_ro;
  logic              w_ok;
  logic              w_unmapped;
  logic              w_ro_wr;
  logic              w_timeout;
  logic              w_err_gnt;

  logic [CW-1:0]     r_wait;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [7:0]        r_err_cnt;
  logic [ADDR_W-1:0] r_err_addr;
  cause_e            r_cause;

  bus_addr_decode #(
    .N_TGT  (N_TGT),
    .ADDR_W (ADDR_W),
    .BASES  (BASES),
    .MASKS  (MASKS),
    .IDX_W  (IDX_W)
  ) u_dec (
    .i_addr (host_addr),
    .o_hit  (w_hit),
    .o_sel  (w_sel),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_ro       = w_any & RO_MASK[w_idx];
  assign w_ro_wr    = host_req & host_we & w_ro;
  assign w_unmapped = host_req & ~(|w_hit);

  assign tgt_valid  = host_req
                    ? (w_sel & ~{N_TGT{host_we & w_ro}})
                    : '0;
  assign tgt_addr   = host_addr;
  assign tgt_wdata  = host_wdata;
  assign tgt_wstrb  = host_we ? host_be : '0;

  // Only the winner's ready counts; others are ignored.
  assign w_ok       = tgt_valid[w_idx] & tgt_ready[w_idx];
  assign w_timeout  = (r_wait == W_MAX) & ~w_ok;
  assign host_gnt   = host_req
                    & (w_ok | w_unmapped | w_ro_wr | w_timeout);
  assign w_err_gnt  = host_gnt & ~w_ok;

  // Wait counter: counts stalled cycles of a pending request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wait <= '0;
    end else if (host_gnt || !host_req) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Response register, reloaded every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= host_gnt;
      r_rdata  <= (w_ok && !host_we)
                ? tgt_rdata[w_idx*DATA_W +: DATA_W]
                : '0;
      r_err    <= w_err_gnt;
    end
  end

  // Error log: saturating count plus last address/cause.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_cause    <= CAUSE_NONE;
    end else if (w_err_gnt) begin
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      r_err_addr <= host_addr;
      if (w_unmapped) begin
        r_cause <= CAUSE_UNMAPPED;
      end else if (w_ro_wr) begin
        r_cause <= CAUSE_RO_WRITE;
      end else begin
        r_cause <= CAUSE_TIMEOUT;
      end
    end
  end

  assign host_rvalid    = r_rvalid;
  assign host_rdata     = r_rdata;
  assign host_err       = r_err;
  assign err_count      = r_err_cnt;
  assign last_err_addr  = r_err_addr;
  assign last_err_cause = r_cause;

endmodule
